// File: rtl/thd_pkg.sv
// Shared constants and types for the THD ratio unit.
//   AMP_W   : width of one harmonic power value
//   SUM_W   : width of the four-harmonic sum (two guard bits, cannot overflow)
//   SCALE   : fixed-point scale applied to the harmonic sum
//   NUM_W   : width of the scaled numerator (exact product width)
//   OUT_W   : width of the reported THD value
//   THD_SAT : value reported on divide-by-zero or quotient overflow
package thd_pkg;

    localparam int AMP_W   = 24;
    localparam int SUM_W   = AMP_W + 2;
    localparam int SCALE_W = 27;
    localparam int NUM_W   = SUM_W + SCALE_W;
    localparam int OUT_W   = 40;
    localparam int CNT_W   = $clog2(NUM_W);

    localparam logic [SCALE_W-1:0] SCALE   = 27'd100000000;
    localparam logic [OUT_W-1:0]   THD_SAT = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SUM  = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_FIN  = 3'd4
    } thd_state_t;

endpackage

// File: rtl/thd_div_seq.sv
// Serial unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk, rst : clock and synchronous active-high reset
//   go       : one-cycle pulse; dividend/divisor are consumed in this cycle,
//              which is also the first of NUM_W iterations
//   dividend : NUM_W-bit numerator
//   divisor  : AMP_W-bit denominator (must be nonzero; the caller filters 0)
//   quotient : result of the iteration performed in the current cycle;
//              holds the complete quotient while fin is high
//   fin      : high in the cycle of the last (NUM_W-th) iteration
module thd_div_seq
    import thd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [NUM_W-1:0] dividend,
    input  logic [AMP_W-1:0] divisor,
    output logic [NUM_W-1:0] quotient,
    output logic             fin
);

    logic [AMP_W:0]   rem_reg;
    logic [NUM_W-1:0] work_reg;   // dividend bits shift out the top, quotient bits in the bottom
    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg;

    logic [NUM_W-1:0] src_bits;
    logic [AMP_W:0]   src_rem;
    logic [AMP_W:0]   trial;
    logic             take;
    logic [AMP_W:0]   rem_next;
    logic [NUM_W-1:0] work_next;

    // The go cycle already performs iteration 0 on the fresh operands, so the
    // whole division occupies exactly NUM_W cycles.
    always_comb begin
        src_bits  = go ? dividend : work_reg;
        src_rem   = go ? '0 : rem_reg;
        // Remainder is always below divisor, so its top bit is free for the shift.
        trial     = {src_rem[AMP_W-1:0], src_bits[NUM_W-1]};
        take      = (trial >= {1'b0, divisor});
        rem_next  = take ? (trial - {1'b0, divisor}) : trial;
        work_next = {src_bits[NUM_W-2:0], take};
    end

    assign quotient = work_next;
    assign fin      = active_reg && (cnt_reg == CNT_W'(NUM_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg    <= '0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (go) begin
            rem_reg    <= rem_next;
            work_reg   <= work_next;
            cnt_reg    <= CNT_W'(1);
            active_reg <= 1'b1;
        end else if (active_reg) begin
            rem_reg  <= rem_next;
            work_reg <= work_next;
            cnt_reg  <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(NUM_W - 1)) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/thd_calc_seq.sv
// Multi-cycle THD ratio: thd = SCALE * (amp_2+amp_3+amp_4+amp_5) / amp_1.
//   clk, rst      : clock and synchronous active-high reset (aborts any operation)
//   start         : one-cycle request, accepted only in IDLE; amps valid with it
//   amp_1         : fundamental power (divisor)
//   amp_2..amp_5  : harmonic powers
//   busy          : high from the cycle after an accepted start through done
//   done          : one-cycle pulse; thd/div_zero/sat valid from this cycle
//   thd           : truncated quotient, or all ones on zero divisor / overflow
//   div_zero      : last result had amp_1 == 0
//   sat           : last quotient did not fit in OUT_W bits
// Normal latency: done 56 cycles after start (SUM, MUL, 53 x DIV, FIN).
// Zero-divisor latency: done 2 cycles after start (SUM, FIN).
module thd_calc_seq
    import thd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMP_W-1:0] amp_1,
    input  logic [AMP_W-1:0] amp_2,
    input  logic [AMP_W-1:0] amp_3,
    input  logic [AMP_W-1:0] amp_4,
    input  logic [AMP_W-1:0] amp_5,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] thd,
    output logic             div_zero,
    output logic             sat
);

    thd_state_t       state_reg;
    logic [AMP_W-1:0] amp1_reg;
    logic [AMP_W-1:0] harm_reg [4];
    logic [SUM_W-1:0] sum_r;
    logic [NUM_W-1:0] num_r;
    logic             div_go_reg;

    logic [SUM_W-1:0] sum_next;
    logic [NUM_W-1:0] div_quotient;
    logic             div_fin;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < 4; i++) begin
            sum_next = sum_next + SUM_W'(harm_reg[i]);
        end
    end

    thd_div_seq u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (div_go_reg),
        .dividend (num_r),
        .divisor  (amp1_reg),
        .quotient (div_quotient),
        .fin      (div_fin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            thd        <= '0;
            div_zero   <= 1'b0;
            sat        <= 1'b0;
            amp1_reg   <= '0;
            sum_r      <= '0;
            num_r      <= '0;
            div_go_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                harm_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        amp1_reg    <= amp_1;
                        harm_reg[0] <= amp_2;
                        harm_reg[1] <= amp_3;
                        harm_reg[2] <= amp_4;
                        harm_reg[3] <= amp_5;
                        busy        <= 1'b1;
                        state_reg   <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    sum_r <= sum_next;
                    if (amp1_reg == '0) begin
                        // Skip the divider entirely and report the sentinel.
                        thd       <= THD_SAT;
                        div_zero  <= 1'b1;
                        sat       <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_FIN;
                    end else begin
                        state_reg <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    num_r      <= NUM_W'(sum_r) * NUM_W'(SCALE);
                    div_go_reg <= 1'b1;
                    state_reg  <= ST_DIV;
                end
                ST_DIV: begin
                    div_go_reg <= 1'b0;
                    // div_quotient is the completed quotient in the fin cycle.
                    if (div_fin) begin
                        if (div_quotient[NUM_W-1:OUT_W] != '0) begin
                            thd <= THD_SAT;
                            sat <= 1'b1;
                        end else begin
                            thd <= div_quotient[OUT_W-1:0];
                            sat <= 1'b0;
                        end
                        div_zero  <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thd_calc_seq.sv
// Bench for thd_calc_seq: a cycle-level reference model (plain 64-bit
// arithmetic and operation timing) checked against the DUT on every cycle,
// plus directed operations with hand-computed expected results.
module tb_thd_calc_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] amp_1, amp_2, amp_3, amp_4, amp_5;
    logic        busy;
    logic        done;
    logic [39:0] thd;
    logic        div_zero;
    logic        sat;

    int total = 0;
    int bad   = 0;

    thd_calc_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .amp_1    (amp_1),
        .amp_2    (amp_2),
        .amp_3    (amp_3),
        .amp_4    (amp_4),
        .amp_5    (amp_5),
        .busy     (busy),
        .done     (done),
        .thd      (thd),
        .div_zero (div_zero),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result of one operation from the arithmetic definition.
    function automatic void expect_of(input logic [23:0] a1, a2, a3, a4, a5,
                                      output logic [39:0] t, output logic dz,
                                      output logic st, output int lat);
        logic [63:0] s, num, q;
        s   = 64'(a2) + 64'(a3) + 64'(a4) + 64'(a5);
        num = s * 64'd100000000;
        if (a1 == 24'd0) begin
            t = '1; dz = 1'b1; st = 1'b0; lat = 2;
        end else begin
            q   = num / 64'(a1);
            dz  = 1'b0;
            lat = 56;
            if (q > 64'h00FF_FFFF_FFFF) begin
                t = '1; st = 1'b1;
            end else begin
                t = q[39:0]; st = 1'b0;
            end
        end
    endfunction

    // Reference model state, advanced on every rising edge from the inputs.
    int          cyc;
    bit          op_valid;
    int          op_start, op_done;
    logic [39:0] op_thd, m_thd;
    logic        op_dz, op_sat, m_dz, m_sat;

    initial begin
        cyc = 0; op_valid = 0; op_start = 0; op_done = 0;
        op_thd = '0; op_dz = 0; op_sat = 0;
        m_thd = '0; m_dz = 0; m_sat = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                op_valid = 0;
                m_thd = '0; m_dz = 0; m_sat = 0;
            end else begin
                if (op_valid && cyc == op_done) begin
                    m_thd = op_thd; m_dz = op_dz; m_sat = op_sat;
                end
                if (start && !(op_valid && (cyc - 1) <= op_done)) begin
                    int lat;
                    expect_of(amp_1, amp_2, amp_3, amp_4, amp_5, op_thd, op_dz, op_sat, lat);
                    op_start = cyc - 1;
                    op_done  = op_start + lat;
                    op_valid = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("cyc_busy", 64'(busy), 64'(op_valid && cyc > op_start && cyc <= op_done));
                chk("cyc_done", 64'(done), 64'(op_valid && cyc == op_done));
                chk("cyc_thd", 64'(thd), 64'(m_thd));
                chk("cyc_div_zero", 64'(div_zero), 64'(m_dz));
                chk("cyc_sat", 64'(sat), 64'(m_sat));
            end
        end
    end

    task automatic set_amps(input logic [23:0] a1, a2, a3, a4, a5);
        amp_1 = a1; amp_2 = a2; amp_3 = a3; amp_4 = a4; amp_5 = a5;
    endtask

    task automatic do_op(input logic [23:0] a1, a2, a3, a4, a5,
                         input logic [39:0] e_thd, input logic e_dz, input logic e_sat,
                         input int e_lat);
        int n, nb;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1;
        set_amps(a1, a2, a3, a4, a5);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nb = 0; seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) seen = 1;
        end
        chk("done_latency", seen ? 64'(n) : 64'd0, 64'(e_lat));
        chk("busy_cycles", 64'(nb), 64'(e_lat));
        chk("thd", 64'(thd), 64'(e_thd));
        chk("div_zero", 64'(div_zero), 64'(e_dz));
        chk("sat", 64'(sat), 64'(e_sat));
        $display("op a1=%0d a2=%0d a3=%0d a4=%0d a5=%0d -> thd=%0h dz=%0d sat=%0d latency=%0d",
                 a1, a2, a3, a4, a5, thd, div_zero, sat, n);
    endtask

    initial begin
        int dones, done_at;
        rst = 1'b1;
        start = 1'b0;
        set_amps(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_thd", 64'(thd), 64'd0);
        rst = 1'b0;

        do_op(24'd1000, 24'd10, 0, 0, 0, 40'd1000000, 1'b0, 1'b0, 56);
        do_op(24'd3, 24'd1, 0, 0, 0, 40'd33333333, 1'b0, 1'b0, 56);
        do_op(24'd0, 24'd5, 0, 0, 0, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 2);
        do_op(24'd1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
              40'hFF_FFFF_FFFF, 1'b0, 1'b1, 56);
        do_op(24'd12345, 24'd100, 24'd200, 24'd300, 24'd400, 40'd8100445, 1'b0, 1'b0, 56);
        do_op(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
              40'd400000000, 1'b0, 1'b0, 56);

        // Extra start pulses while busy and in the done cycle must be ignored.
        @(posedge clk); #1;
        start = 1'b1;
        set_amps(24'd1000, 24'd10, 0, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; done_at = 0;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                done_at = n;
            end
            if (n == 10 || n == 56) begin
                start = 1'b1;
                set_amps(24'd7, 24'd777, 24'd5, 0, 0);
            end else begin
                start = 1'b0;
            end
        end
        chk("b2b_done_count", 64'(dones), 64'd1);
        chk("b2b_done_at", 64'(done_at), 64'd56);
        chk("b2b_thd", 64'(thd), 64'd1000000);
        $display("op back-to-back: dones=%0d done_at=%0d thd=%0h", dones, done_at, thd);

        // Reset in the middle of a division aborts it with no done pulse.
        @(posedge clk); #1;
        start = 1'b1;
        set_amps(24'd3, 24'd1, 0, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (done) dones++;
            if (n == 20) rst = 1'b1;
            if (n == 21) begin
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_thd", 64'(thd), 64'd0);
                chk("abort_div_zero", 64'(div_zero), 64'd0);
                chk("abort_sat", 64'(sat), 64'd0);
                rst = 1'b0;
            end
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        $display("op reset-abort: dones=%0d thd=%0h", dones, thd);

        do_op(24'd1000, 24'd10, 0, 0, 0, 40'd1000000, 1'b0, 1'b0, 56);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
